// File: rtl/spi_pkg.sv
// Shared definitions for the parameterised SPI slave: FSM state encoding,
// command codes and a helper for sizing the frame bit counter.
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RECV    = 3'd1,
      ST_WAIT_TX = 3'd2,
      ST_SEND    = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // Two command bits lead every frame, always sent cmd[1] first.
   localparam int CMD_W = 2;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   // Counter wide enough to hold 0..frame_w without wrapping.
   function automatic int cnt_width(input int frame_w);
      return $clog2(frame_w + 1);
   endfunction

endpackage

// File: rtl/spi_slave_param_if.sv
// Bus bundle between an SPI master (or bench) and spi_slave_param.
//
// Handshake semantics:
//   - tx_valid/tx_data are looked at only while the slave waits for read-back
//     data (state WAIT_TX). The first rising edge in WAIT_TX that sees
//     tx_valid high captures tx_data; there is no ready signal, the capture
//     is visible as the move to SEND. Outside WAIT_TX both are ignored.
//   - rx_valid is a single-cycle pulse with no back-pressure; rx_data is held
//     stable until the next complete frame (or reset).
//   - state is a debug view of the slave FSM.
interface spi_slave_param_if
   import spi_pkg::*;
#(
   parameter int DATA_W = 8
);
   localparam int FRAME_W = DATA_W + CMD_W;

   logic               ss_n;
   logic               mosi;
   logic               tx_valid;
   logic [DATA_W-1:0]  tx_data;
   logic               miso;
   logic               rx_valid;
   logic [FRAME_W-1:0] rx_data;
   logic               busy;
   state_t             state;

   modport master (
      output ss_n, mosi, tx_valid, tx_data,
      input  miso, rx_valid, rx_data, busy, state
   );

   modport slave (
      input  ss_n, mosi, tx_valid, tx_data,
      output miso, rx_valid, rx_data, busy, state
   );

endinterface

// File: rtl/spi_shift_reg.sv
// Parallel-load / serial shift register used for both the receive payload
// and the transmit payload. Exposes the value it will hold after the current
// edge so the parent can register a complete word or the next serial bit in
// the same cycle the shift happens.
module spi_shift_reg #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_data_i,
   input  logic             shift_i,
   input  logic             ser_i,
   output logic [WIDTH-1:0] next_o,
   output logic             ser_next_o
);

   logic [WIDTH-1:0] data_q, data_d;

   // Load has priority over shift; direction follows MSB_FIRST.
   always_comb begin
      data_d = data_q;
      if (load_i) begin
         data_d = load_data_i;
      end else if (shift_i) begin
         if (MSB_FIRST) data_d = {data_q[WIDTH-2:0], ser_i};
         else           data_d = {ser_i, data_q[WIDTH-1:1]};
      end
   end

   // Register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= data_d;
   end

   assign next_o     = data_d;
   assign ser_next_o = MSB_FIRST ? data_d[WIDTH-1] : data_d[0];

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave: receives a {cmd[1:0], payload} frame on mosi, reports it on
// rx_data/rx_valid, and for a read-data command waits for tx_data and shifts
// it out on miso. ss_n high aborts any frame in progress.
module spi_slave_param
   import spi_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   spi_slave_param_if.slave bus
);

   localparam int FRAME_W = DATA_W + CMD_W;
   localparam int CNT_W   = cnt_width(FRAME_W);
   localparam logic [CNT_W-1:0] LAST_RX  = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] LAST_TX  = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CMD_BITS = CNT_W'(CMD_W);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          cmd_q, cmd_d;
   logic                miso_q, miso_d;
   logic                rx_valid_q, rx_valid_d;
   logic [FRAME_W-1:0]  rx_data_q, rx_data_d;

   logic                rx_shift;
   logic                tx_load;
   logic                tx_shift;
   logic [DATA_W-1:0]   rx_next;
   logic                tx_ser_next;
   logic                rx_ser_unused;
   logic [DATA_W-1:0]   tx_next_unused;

   spi_shift_reg #(.WIDTH(DATA_W), .MSB_FIRST(MSB_FIRST)) u_rx_sr (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (1'b0),
      .load_data_i ('0),
      .shift_i     (rx_shift),
      .ser_i       (bus.mosi),
      .next_o      (rx_next),
      .ser_next_o  (rx_ser_unused)
   );

   spi_shift_reg #(.WIDTH(DATA_W), .MSB_FIRST(MSB_FIRST)) u_tx_sr (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (tx_load),
      .load_data_i (bus.tx_data),
      .shift_i     (tx_shift),
      .ser_i       (1'b0),
      .next_o      (tx_next_unused),
      .ser_next_o  (tx_ser_next)
   );

   // Next-state and datapath control; miso and rx_valid default to 0 so they
   // are only asserted by the branches that explicitly drive them.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cmd_d      = cmd_q;
      miso_d     = 1'b0;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;
      rx_shift   = 1'b0;
      tx_load    = 1'b0;
      tx_shift   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!bus.ss_n) begin
               state_d = ST_RECV;
               cnt_d   = '0;
            end
         end
         ST_RECV: begin
            if (bus.ss_n) begin
               state_d = ST_IDLE;
            end else begin
               // Command bits are always sent cmd[1] first; payload goes
               // through the shift register in MSB_FIRST order.
               if (cnt_q < CMD_BITS) cmd_d = {cmd_q[0], bus.mosi};
               else                  rx_shift = 1'b1;
               if (cnt_q == LAST_RX) begin
                  rx_data_d  = {cmd_q, rx_next};
                  rx_valid_d = 1'b1;
                  state_d    = (cmd_q == CMD_RD_DATA) ? ST_WAIT_TX : ST_DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_WAIT_TX: begin
            if (bus.ss_n) begin
               state_d = ST_IDLE;
            end else if (bus.tx_valid) begin
               tx_load = 1'b1;
               miso_d  = tx_ser_next;
               cnt_d   = '0;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (bus.ss_n) begin
               state_d = ST_IDLE;
            end else if (cnt_q == LAST_TX) begin
               state_d = ST_DONE;
            end else begin
               tx_shift = 1'b1;
               miso_d   = tx_ser_next;
               cnt_d    = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.ss_n) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         cmd_q      <= '0;
         miso_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cmd_q      <= cmd_d;
         miso_q     <= miso_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
      end
   end

   assign bus.miso     = miso_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.busy     = (state_q != ST_IDLE);
   assign bus.state    = state_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: an 8-bit MSB-first slave and a 16-bit LSB-first
// slave driven with directed and random frames; a monitor compares rx_data
// and miso against expectations queued by the stimulus tasks.
module tb_spi_slave_param;
   import spi_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   spi_slave_param_if #(.DATA_W(8))  bus8 ();
   spi_slave_param_if #(.DATA_W(16)) bus16 ();

   spi_slave_param #(.DATA_W(8), .MSB_FIRST(1'b1)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   spi_slave_param #(.DATA_W(16), .MSB_FIRST(1'b0)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [9:0]  exp_rx8_q[$];
   logic [17:0] exp_rx16_q[$];
   logic        exp_miso8_q[$];
   logic        exp_miso16_q[$];
   logic [9:0]  last_rx8  = '0;
   logic [17:0] last_rx16 = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   logic m8_bit, m16_bit;
   always @(posedge clk) begin
      #2;
      if (bus8.rx_valid !== 1'b0) begin
         if (exp_rx8_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rx8_unexpected_valid: got rx_data 0x%0h, expected no rx_valid", bus8.rx_data);
         end else begin
            check("rx8_data", 32'(bus8.rx_data), 32'(exp_rx8_q.pop_front()));
         end
      end
      if (bus16.rx_valid !== 1'b0) begin
         if (exp_rx16_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rx16_unexpected_valid: got rx_data 0x%0h, expected no rx_valid", bus16.rx_data);
         end else begin
            check("rx16_data", 32'(bus16.rx_data), 32'(exp_rx16_q.pop_front()));
         end
      end
      m8_bit  = (exp_miso8_q.size()  > 0) ? exp_miso8_q.pop_front()  : 1'b0;
      m16_bit = (exp_miso16_q.size() > 0) ? exp_miso16_q.pop_front() : 1'b0;
      check("miso8",  32'(bus8.miso),  32'(m8_bit));
      check("miso16", 32'(bus16.miso), 32'(m16_bit));
   end

   // ---------------- pin access helpers ----------------
   task automatic set_pins(input int sel, input logic ss, input logic m);
      if (sel == 0) begin bus8.ss_n  = ss; bus8.mosi  = m; end
      else          begin bus16.ss_n = ss; bus16.mosi = m; end
   endtask

   task automatic set_tx(input int sel, input logic v, input logic [31:0] d);
      if (sel == 0) begin bus8.tx_valid  = v; bus8.tx_data  = d[7:0];  end
      else          begin bus16.tx_valid = v; bus16.tx_data = d[15:0]; end
   endtask

   function automatic logic [31:0] get_rx(input int sel);
      return (sel == 0) ? 32'(bus8.rx_data) : 32'(bus16.rx_data);
   endfunction

   function automatic logic get_busy(input int sel);
      return (sel == 0) ? bus8.busy : bus16.busy;
   endfunction

   function automatic logic [2:0] get_state(input int sel);
      return (sel == 0) ? bus8.state : bus16.state;
   endfunction

   function automatic logic [31:0] get_last(input int sel);
      return (sel == 0) ? 32'(last_rx8) : 32'(last_rx16);
   endfunction

   task automatic push_miso(input int sel, input logic b);
      if (sel == 0) exp_miso8_q.push_back(b);
      else          exp_miso16_q.push_back(b);
   endtask

   // ---------------- driver tasks ----------------
   // Select the slave, then drive the first nbits of the frame. A full frame
   // queues its expected rx_data, which is just {cmd, payload}.
   task automatic send_frame(input int sel, input logic [1:0] cmd, input logic [31:0] payload,
                             input int nbits, input bit txv_noise);
      int   dw  = (sel == 0) ? 8 : 16;
      bit   msb = (sel == 0);
      logic bits[$];
      bits.push_back(cmd[1]);
      bits.push_back(cmd[0]);
      for (int i = 0; i < dw; i++) bits.push_back(msb ? payload[dw-1-i] : payload[i]);
      if (nbits == dw + 2) begin
         if (sel == 0) begin
            exp_rx8_q.push_back({cmd, payload[7:0]});
            last_rx8 = {cmd, payload[7:0]};
         end else begin
            exp_rx16_q.push_back({cmd, payload[15:0]});
            last_rx16 = {cmd, payload[15:0]};
         end
      end
      @(negedge clk);
      set_pins(sel, 1'b0, 1'($urandom_range(0, 1)));
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         set_pins(sel, 1'b0, bits[i]);
         if (txv_noise) set_tx(sel, 1'($urandom_range(0, 1)), $urandom);
      end
   endtask

   // After a read-data frame: offer tx_data after 'delay' cycles (or already
   // during the last frame bit when 'early'), queue the expected miso bits.
   task automatic finish_read(input int sel, input logic [31:0] txd, input int delay, input bit early);
      int dw  = (sel == 0) ? 8 : 16;
      bit msb = (sel == 0);
      if (early) set_tx(sel, 1'b1, txd);
      else       set_tx(sel, 1'b0, $urandom);
      for (int d = 0; d < delay; d++) begin
         @(negedge clk);
         set_tx(sel, 1'b0, $urandom);
      end
      @(negedge clk);
      set_tx(sel, 1'b1, txd);
      for (int i = 0; i < dw; i++) push_miso(sel, msb ? txd[dw-1-i] : txd[i]);
      @(negedge clk);
      set_tx(sel, 1'b0, $urandom);
      repeat (dw) @(negedge clk);
      check("read_state_done", 32'(get_state(sel)), 32'(ST_DONE));
      check("read_busy", 32'(get_busy(sel)), 32'd1);
   endtask

   // DONE ignores mosi; ss_n high returns to IDLE.
   task automatic end_frame(input int sel);
      repeat (2) begin
         @(negedge clk);
         set_pins(sel, 1'b0, 1'($urandom_range(0, 1)));
      end
      check("done_holds", 32'(get_state(sel)), 32'(ST_DONE));
      @(negedge clk);
      set_pins(sel, 1'b1, 1'b0);
      set_tx(sel, 1'b0, 32'd0);
      @(negedge clk);
      check("end_busy", 32'(get_busy(sel)), 32'd0);
      check("end_state_idle", 32'(get_state(sel)), 32'(ST_IDLE));
   endtask

   // Raise ss_n after a partial frame: no rx_valid, rx_data unchanged.
   task automatic abort_frame(input int sel);
      @(negedge clk);
      set_pins(sel, 1'b1, 1'b0);
      set_tx(sel, 1'b0, 32'd0);
      @(negedge clk);
      check("abort_busy", 32'(get_busy(sel)), 32'd0);
      check("abort_rx_data_kept", get_rx(sel), get_last(sel));
   endtask

   // Read frame interrupted after k miso bits, by ss_n or by reset.
   task automatic abort_send(input int sel, input logic [31:0] txd, input int k, input bit use_reset);
      int dw  = (sel == 0) ? 8 : 16;
      bit msb = (sel == 0);
      send_frame(sel, 2'b11, $urandom, dw + 2, 1'b0);
      set_tx(sel, 1'b0, 32'd0);
      @(negedge clk);
      set_tx(sel, 1'b1, txd);
      for (int i = 0; i < dw; i++) push_miso(sel, msb ? txd[dw-1-i] : txd[i]);
      @(negedge clk);
      set_tx(sel, 1'b0, $urandom);
      repeat (k - 1) @(negedge clk);
      exp_miso8_q.delete();
      exp_miso16_q.delete();
      if (use_reset) begin
         rst_n = 1'b0;
         last_rx8  = '0;
         last_rx16 = '0;
         #1;
         check("rst_miso", 32'(bus8.miso), 32'd0);
         check("rst_busy", 32'(bus8.busy), 32'd0);
         check("rst_state", 32'(bus8.state), 32'(ST_IDLE));
         check("rst_rx_data", 32'(bus8.rx_data), 32'd0);
         set_pins(0, 1'b1, 1'b0);
         set_pins(1, 1'b1, 1'b0);
         set_tx(0, 1'b0, 32'd0);
         set_tx(1, 1'b0, 32'd0);
         @(negedge clk);
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
      end else begin
         set_pins(sel, 1'b1, 1'b0);
         @(negedge clk);
         check("send_abort_busy", 32'(get_busy(sel)), 32'd0);
         check("send_abort_rx_kept", get_rx(sel), get_last(sel));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      set_pins(0, 1'b1, 1'b0);
      set_pins(1, 1'b1, 1'b0);
      set_tx(0, 1'b0, 32'd0);
      set_tx(1, 1'b0, 32'd0);
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         check("reset_rx_data", get_rx(s), 32'd0);
         check("reset_busy", 32'(get_busy(s)), 32'd0);
         check("reset_state", 32'(get_state(s)), 32'(ST_IDLE));
      end
      check("reset_rx_valid8", 32'(bus8.rx_valid), 32'd0);
      check("reset_miso16", 32'(bus16.miso), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Write-address frame 00 + 0xA5, MSB first.
      send_frame(0, CMD_WR_ADDR, 32'hA5, 10, 1'b0);
      check("busy_in_frame", 32'(bus8.busy), 32'd1);
      @(negedge clk);
      check("a5_rx_valid_high", 32'(bus8.rx_valid), 32'd1);
      check("a5_rx_data", 32'(bus8.rx_data), 32'h0A5);
      @(negedge clk);
      check("a5_rx_valid_low", 32'(bus8.rx_valid), 32'd0);
      end_frame(0);

      // Read-data frame, tx_valid three cycles after rx_valid, data 0x3C.
      send_frame(0, CMD_RD_DATA, 32'h00, 10, 1'b0);
      finish_read(0, 32'h3C, 3, 1'b0);
      end_frame(0);

      // Partial write frame (5 bits) aborted.
      send_frame(0, CMD_WR_DATA, $urandom, 5, 1'b0);
      abort_frame(0);

      // Read frame aborted while waiting for tx data.
      send_frame(0, CMD_RD_DATA, $urandom, 10, 1'b0);
      set_tx(0, 1'b0, 32'd0);
      abort_frame(0);

      // Read frame aborted by ss_n mid-send on the 16-bit slave.
      abort_send(1, $urandom, 5, 1'b0);

      // Reset at SEND bit 4, then a clean write frame 01 + 0x5A.
      abort_send(0, $urandom, 4, 1'b1);
      send_frame(0, CMD_WR_DATA, 32'h5A, 10, 1'b0);
      @(negedge clk);
      check("post_reset_rx_data", 32'(bus8.rx_data), 32'h15A);
      end_frame(0);

      // 16-bit LSB-first frame 01 + 0x1234.
      send_frame(1, CMD_WR_DATA, 32'h1234, 18, 1'b0);
      @(negedge clk);
      check("w16_rx_valid_high", 32'(bus16.rx_valid), 32'd1);
      check("w16_rx_data", 32'(bus16.rx_data), 32'h11234);
      @(negedge clk);
      check("w16_rx_valid_low", 32'(bus16.rx_valid), 32'd0);
      end_frame(1);

      // 16-bit read with tx_valid already high on WAIT_TX entry.
      send_frame(1, CMD_RD_DATA, $urandom, 18, 1'b1);
      finish_read(1, $urandom, 0, 1'b1);
      end_frame(1);

      // Random traffic on both slaves.
      for (int n = 0; n < 30; n++) begin
         int          sel = $urandom_range(0, 1);
         int          fw  = (sel == 0) ? 10 : 18;
         logic [1:0]  cmd = 2'($urandom_range(0, 3));
         logic [31:0] pl  = $urandom;
         if ($urandom_range(0, 4) == 0) begin
            send_frame(sel, cmd, pl, $urandom_range(1, fw - 1), 1'b1);
            abort_frame(sel);
         end else if (cmd == CMD_RD_DATA) begin
            bit early = 1'($urandom_range(0, 1));
            send_frame(sel, cmd, pl, fw, 1'b1);
            finish_read(sel, $urandom, early ? 0 : $urandom_range(0, 4), early);
            end_frame(sel);
         end else begin
            send_frame(sel, cmd, pl, fw, 1'b1);
            end_frame(sel);
         end
      end

      repeat (4) @(negedge clk);
      check("rx8_queue_drained", 32'(exp_rx8_q.size()), 32'd0);
      check("rx16_queue_drained", 32'(exp_rx16_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 Parameter DATA_W, default 8: payload bits per frame; legal range 4..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift MSB first on mosi and miso, 0 = LSB first.
REQ-003 Derived constant FRAME_W = DATA_W+2: 2 command bits followed by DATA_W payload bits.
REQ-004 clk  in  1  serial/system clock; all sampling on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 ss_n  in  1  slave select, active-low; high aborts or ends a frame.
REQ-007 mosi  in  1  serial data from master.
REQ-008 tx_valid  in  1  tx_data holds valid read-back data.
REQ-009 tx_data  in  DATA_W  read-back payload.
REQ-010 miso  out  1  serial data to master, registered.
REQ-011 rx_valid  out  1  one-cycle pulse: rx_data holds a complete frame.
REQ-012 rx_data  out  FRAME_W  {cmd[1:0], payload}, registered.
REQ-013 busy  out  1  high whenever state != IDLE.

Function
REQ-014 States: IDLE, RECV, WAIT_TX, SEND, DONE; binary-encoded, 3 bits.
REQ-015 IDLE: ss_n low sampled -> RECV; bit counter cleared to 0.
REQ-016 RECV: each edge with ss_n low shifts mosi into the rx shift register per MSB_FIRST and increments the counter.
REQ-017 Frame bits always arrive command first (cmd[1] then cmd[0]); MSB_FIRST governs payload order only.
REQ-018 On the edge that samples bit FRAME_W-1, rx_data loads the complete frame and rx_valid is high for exactly the following cycle.
REQ-019 Command encoding: 00 write address, 01 write data, 10 read address, 11 read data.
REQ-020 End of RECV: cmd 11 -> WAIT_TX; any other cmd -> DONE.
REQ-021 WAIT_TX: holds until tx_valid sampled high; that edge captures tx_data into the tx shift register, drives miso with the first payload bit, clears the counter, and enters SEND.
REQ-022 SEND: each edge shifts out the next bit; after DATA_W bits have been driven, miso returns to 0 and state -> DONE.
REQ-023 tx_valid and tx_data are ignored outside WAIT_TX; a tx_valid already high on WAIT_TX entry is accepted on the first WAIT_TX edge.
REQ-024 DONE: ignores mosi; ss_n high -> IDLE.
REQ-025 miso = 0 in every state except SEND.
REQ-026 ss_n sampled high in RECV, WAIT_TX or SEND -> IDLE on that edge; rx_valid is not raised for a partial frame; rx_data keeps its previous value; miso -> 0.
REQ-027 The bit counter is ceil(log2(FRAME_W+1)) bits wide and never wraps within a frame.
REQ-028 Back-to-back frames need ss_n high for at least one sampled edge between frames.

Reset
REQ-029 rst_n low: state = IDLE; miso, rx_valid and busy = 0; rx_data, shift registers and counter = 0; applied immediately, asynchronously.
REQ-030 Reset mid-frame discards the frame; no rx_valid pulse is produced after reset release until a new complete frame arrives.

Structure
REQ-031 The state encoding and command codes live in shared package spi_pkg, with CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR and CMD_RD_DATA.
REQ-032 One sub-module, spi_shift_reg (parameter WIDTH, MSB_FIRST; load, shift, serial in/out), is instantiated twice: once for rx and once for tx.

Verification
REQ-033 DATA_W=8, ss_n low, mosi = 00 then 0xA5 MSB first -> rx_data = 0x0A5; rx_valid high for exactly 1 cycle after the 10th bit; miso = 0 throughout.
REQ-034 Frame 11 with payload 0x00, tx_valid raised 3 cycles after rx_valid with tx_data = 0x3C -> miso = 0,0,1,1,1,1,0,0 on the 8 following edges, then 0; state = DONE.
REQ-035 ss_n raised after 5 bits of a write frame -> no rx_valid; busy = 0 on the next cycle; rx_data unchanged.
REQ-036 rst_n asserted at SEND bit 4 -> miso and busy = 0 immediately; the next full write frame 01 + 0x5A yields rx_data = 0x15A.
REQ-037 DATA_W=16, MSB_FIRST=0, frame 01 + 0x1234 sent LSB first -> rx_data = {2'b01, 16'h1234}; rx_valid pulses after bit 18.
